spi_master: RTL

Single-byte SPI master for driving the FPGA's SPI slave port (or any mode-3, MSB-first SPI slave) from fabric logic in the `sys_clk` domain. The block frames each byte with its own CS_N assertion, generates SCK by dividing `sys_clk`, shifts `txd_data` out on MOSI and captures MISO into `rxd_data`. Each CS_N frame carries exactly one byte, because the slave restarts its bit count and raises its receive flag on every CS_N rising edge.

---
 rtl/spi_master_if.sv | 30 +++
 rtl/spi_master.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/spi_master_if.sv
// ============================================================================
// Module      : spi_master_if
// Description : Fabric handshake and SPI pin bundle for spi_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_master_if;
    logic       start;
    logic [7:0] txd_data;
    logic       busy;
    logic       done;
    logic [7:0] rxd_data;
    logic       CS_N;
    logic       SCK;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, txd_data, MISO,
        output busy, done, rxd_data, CS_N, SCK, MOSI
    );

    modport slave (
        output start, txd_data, MISO,
        input  busy, done, rxd_data, CS_N, SCK, MOSI
    );
endinterface

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// Module      : spi_master
// Description : Single-byte SPI mode-3 master, MSB first, one byte per CS_N frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master #(
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 100
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    spi_master_if.master      bus
);

    localparam logic [9:0] C_DIV_LAST = 10'(CLK_DIV - 1);
    localparam logic [9:0] C_GAP_LAST = 10'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [9:0] r_cnt,   w_cnt_nxt;
    logic [2:0] r_bit,   w_bit_nxt;
    logic [7:0] r_tx,    w_tx_nxt;
    logic [7:0] r_rx,    w_rx_nxt;
    logic [7:0] r_rxd,   w_rxd_nxt;
    logic       r_cs_n,  w_cs_n_nxt;
    logic       r_sck,   w_sck_nxt;
    logic       r_mosi,  w_mosi_nxt;
    logic       r_busy,  w_busy_nxt;
    logic       r_done,  w_done_nxt;
    logic       r_miso_s1, r_miso_s2;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rxd     <= '0;
            r_cs_n    <= 1'b1;
            r_sck     <= 1'b1;
            r_mosi    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_miso_s1 <= 1'b1;
            r_miso_s2 <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_tx      <= w_tx_nxt;
            r_rx      <= w_rx_nxt;
            r_rxd     <= w_rxd_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_sck     <= w_sck_nxt;
            r_mosi    <= w_mosi_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_miso_s1 <= bus.MISO;
            r_miso_s2 <= r_miso_s1;
        end
    end

    // Every output is computed here and registered above, so the pins stay glitch-free.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 10'd1;
        w_bit_nxt   = r_bit;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_rxd_nxt   = r_rxd;
        w_cs_n_nxt  = r_cs_n;
        w_sck_nxt   = r_sck;
        w_mosi_nxt  = r_mosi;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (bus.start) begin
                    w_tx_nxt    = bus.txd_data;
                    w_cs_n_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == C_DIV_LAST) begin
                    w_cnt_nxt   = '0;
                    w_sck_nxt   = 1'b0;
                    w_mosi_nxt  = r_tx[7];
                    w_tx_nxt    = {r_tx[6:0], 1'b0};
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == C_DIV_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_sck) begin
                        w_sck_nxt  = 1'b0;
                        w_mosi_nxt = r_tx[7];
                        w_tx_nxt   = {r_tx[6:0], 1'b0};
                    end else begin
                        w_sck_nxt = 1'b1;
                        w_rx_nxt  = {r_rx[6:0], r_miso_s2};
                        w_bit_nxt = r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (r_cnt == C_DIV_LAST) begin
                    w_cnt_nxt   = '0;
                    w_cs_n_nxt  = 1'b1;
                    w_rxd_nxt   = r_rx;
                    w_done_nxt  = 1'b1;
                    w_mosi_nxt  = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == C_GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.CS_N     = r_cs_n;
    assign bus.SCK      = r_sck;
    assign bus.MOSI     = r_mosi;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rxd_data = r_rxd;

endmodule

`default_nettype wire
